// File: rtl/reflet_irq_conditioner_pkg.sv
// Shared constants for the reflet IRQ conditioner: line count, mode encodings, ack index width.
package reflet_irq_conditioner_pkg;

    localparam int unsigned IRQ_LINES = 4;
    localparam int unsigned ACK_ID_W  = 2;

    localparam logic IRQ_MODE_LEVEL = 1'b0;
    localparam logic IRQ_MODE_EDGE  = 1'b1;

endpackage

// File: rtl/reflet_irq_sync.sv
// Parameterized-width, parameterized-depth flop chain with synchronous active-high reset.
module reflet_irq_sync #(
    parameter int unsigned width = 4,
    parameter int unsigned depth = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [width-1:0] din,
    output logic [width-1:0] dout
);

    logic [width-1:0] chain_q [depth];
    logic [width-1:0] chain_d [depth];

    always_comb begin
        chain_d[0] = din;
        for (int unsigned i = 1; i < depth; i++) begin
            chain_d[i] = chain_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < depth; i++) begin
                chain_q[i] <= '0;
            end
        end else begin
            chain_q <= chain_d;
        end
    end

    assign dout = chain_q[depth-1];

endmodule

// File: rtl/reflet_irq_conditioner.sv
// Conditions raw peripheral IRQ lines into per-line level/edge requests for reflet_interrupt.
// Define REFLET_IRQ_SYNC_EN to pass irq_raw through a sync_stages-deep synchronizer.
module reflet_irq_conditioner
    import reflet_irq_conditioner_pkg::*;
#(
    parameter int unsigned nb_lines    = IRQ_LINES,
    parameter int unsigned sync_stages = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [nb_lines-1:0] irq_raw,
    input  logic                cfg_we,
    input  logic [nb_lines-1:0] cfg_mode,
    input  logic                ack_valid,
    input  logic [ACK_ID_W-1:0] ack_id,
    output logic [nb_lines-1:0] ext_int,
    output logic [nb_lines-1:0] mode,
    output logic [nb_lines-1:0] overrun
);

`ifdef REFLET_IRQ_SYNC_EN
    localparam int unsigned SYNC_DEPTH = sync_stages;
`else
    localparam int unsigned SYNC_DEPTH = 1;
`endif

    if (sync_stages < 2) begin : g_bad_sync_stages
        $error("reflet_irq_conditioner: sync_stages must be >= 2");
    end
    if (nb_lines != IRQ_LINES) begin : g_bad_nb_lines
        $error("reflet_irq_conditioner: nb_lines must match reflet_interrupt.ext_int");
    end

    logic [nb_lines-1:0] sync_s;
    logic [nb_lines-1:0] s_prev_q, s_prev_d;
    logic [nb_lines-1:0] pend_q, pend_d;
    logic [nb_lines-1:0] mode_q, mode_d;
    logic [nb_lines-1:0] overrun_q, overrun_d;
    logic [nb_lines-1:0] rise_c, set_c, clr_c, chg_c, ovr_c;

    reflet_irq_sync #(
        .width (nb_lines),
        .depth (SYNC_DEPTH)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .din   (irq_raw),
        .dout  (sync_s)
    );

    // Per-line set/clear terms: level lines track s, edge lines latch rises until acked.
    for (genvar g = 0; g < nb_lines; g++) begin : g_line
        logic ack_hit;
        assign ack_hit  = ack_valid && (ack_id == ACK_ID_W'(g));
        assign rise_c[g] = sync_s[g] & ~s_prev_q[g];
        assign chg_c[g]  = cfg_we && (cfg_mode[g] != mode_q[g]);
        assign set_c[g]  = (mode_q[g] == IRQ_MODE_EDGE) ? rise_c[g] : sync_s[g];
        assign clr_c[g]  = (mode_q[g] == IRQ_MODE_EDGE) ? ack_hit : ~sync_s[g];
        assign ovr_c[g]  = (mode_q[g] == IRQ_MODE_EDGE) && rise_c[g] && pend_q[g] && !ack_hit;
    end

    always_comb begin
        s_prev_d  = sync_s;
        mode_d    = cfg_we ? cfg_mode : mode_q;
        overrun_d = cfg_we ? '0 : (overrun_q | ovr_c);
        pend_d    = pend_q;
        for (int unsigned i = 0; i < nb_lines; i++) begin
            if (chg_c[i]) begin
                pend_d[i] = 1'b0;
            end else if (set_c[i]) begin
                pend_d[i] = 1'b1;
            end else if (clr_c[i]) begin
                pend_d[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s_prev_q  <= '0;
            pend_q    <= '0;
            mode_q    <= '0;
            overrun_q <= '0;
        end else begin
            s_prev_q  <= s_prev_d;
            pend_q    <= pend_d;
            mode_q    <= mode_d;
            overrun_q <= overrun_d;
        end
    end

    assign ext_int = pend_q;
    assign mode    = mode_q;
    assign overrun = overrun_q;

endmodule

// File: tb/tb_reflet_irq_conditioner.sv
// Scoreboard bench for reflet_irq_conditioner: directed stimulus queues expected outputs per cycle.
module tb_reflet_irq_conditioner;

`ifdef REFLET_IRQ_SYNC_EN
    localparam int L = 3;
`else
    localparam int L = 2;
`endif

    typedef struct {
        int          cyc;
        string       name;
        logic [3:0]  ext;
        logic [3:0]  md;
        logic [3:0]  ov;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] irq_raw;
    logic       cfg_we;
    logic [3:0] cfg_mode;
    logic       ack_valid;
    logic [1:0] ack_id;
    logic [3:0] ext_int;
    logic [3:0] mode;
    logic [3:0] overrun;

    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;
    exp_t sb_q[$];

    reflet_irq_conditioner #(
        .nb_lines    (4),
        .sync_stages (2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .irq_raw   (irq_raw),
        .cfg_we    (cfg_we),
        .cfg_mode  (cfg_mode),
        .ack_valid (ack_valid),
        .ack_id    (ack_id),
        .ext_int   (ext_int),
        .mode      (mode),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_at(input int d, input string name,
                             input logic [3:0] e, input logic [3:0] m, input logic [3:0] o);
        exp_t x;
        x.cyc  = cyc + d;
        x.name = name;
        x.ext  = e;
        x.md   = m;
        x.ov   = o;
        sb_q.push_back(x);
    endtask

    // Monitor: compare every queued expectation that falls due on this cycle.
    always @(negedge clk) begin
        for (int i = sb_q.size() - 1; i >= 0; i--) begin
            if (sb_q[i].cyc <= cyc) begin
                n_cmp++;
                if (sb_q[i].cyc < cyc ||
                    ext_int !== sb_q[i].ext || mode !== sb_q[i].md || overrun !== sb_q[i].ov) begin
                    n_err++;
                    $display("FAIL %s cyc=%0d: got ext_int=%h mode=%h overrun=%h, want %h %h %h",
                             sb_q[i].name, cyc, ext_int, mode, overrun,
                             sb_q[i].ext, sb_q[i].md, sb_q[i].ov);
                end
                sb_q.delete(i);
            end
        end
    end

    initial begin
        reset     = 1'b1;
        irq_raw   = 4'hF;
        cfg_we    = 1'b0;
        cfg_mode  = 4'h0;
        ack_valid = 1'b0;
        ack_id    = 2'd0;

        // Reset with all lines high, then release
        step();
        expect_at(0, "reset_a", 4'h0, 4'h0, 4'h0);
        step();
        expect_at(0, "reset_b", 4'h0, 4'h0, 4'h0);
        step();
        reset = 1'b0;
        expect_at(L-1, "rst_lat_lo", 4'h0, 4'h0, 4'h0);
        expect_at(L,   "rst_lat_hi", 4'hF, 4'h0, 4'h0);
        repeat (L+1) step();
        irq_raw = 4'h0;
        repeat (L+1) step();
        expect_at(0, "idle", 4'h0, 4'h0, 4'h0);
        n_cmp++;
        if (ext_int !== 4'h0) begin
            n_err++;
            $display("FAIL idle_direct: got ext_int=%h, want 0", ext_int);
        end

        // Level mode: 5-cycle pulse on line 1, ack ignored
        irq_raw = 4'h2;
        for (int k = L-1; k <= L+5; k++)
            expect_at(k, "lvl_pulse", (k >= L && k <= L+4) ? 4'h2 : 4'h0, 4'h0, 4'h0);
        repeat (2) step();
        ack_valid = 1'b1;
        ack_id    = 2'd1;
        step();
        ack_valid = 1'b0;
        repeat (2) step();
        irq_raw = 4'h0;
        repeat (L+3) step();

        // Switch all lines to edge mode
        cfg_we   = 1'b1;
        cfg_mode = 4'hF;
        expect_at(1, "cfg_edge", 4'h0, 4'hF, 4'h0);
        step();
        cfg_we = 1'b0;
        step();
        n_cmp++;
        if (mode !== 4'hF) begin
            n_err++;
            $display("FAIL cfg_edge_direct: got mode=%h, want f", mode);
        end

        // Edge line 2 rises and stays high; ack clears, no retrigger
        irq_raw = 4'h4;
        expect_at(L-1, "edge2_lo",   4'h0, 4'hF, 4'h0);
        expect_at(L,   "edge2_hi",   4'h4, 4'hF, 4'h0);
        expect_at(L+3, "edge2_hold", 4'h4, 4'hF, 4'h0);
        repeat (L+3) step();
        ack_valid = 1'b1;
        ack_id    = 2'd2;
        expect_at(1, "edge2_ack",   4'h0, 4'hF, 4'h0);
        expect_at(4, "edge2_norearm", 4'h0, 4'hF, 4'h0);
        step();
        ack_valid = 1'b0;
        repeat (3) step();
        irq_raw = 4'h0;
        repeat (L+1) step();

        // Second edge on line 0 before ack -> overrun; cfg_we clears it
        irq_raw = 4'h1;
        repeat (L+1) step();
        irq_raw = 4'h0;
        repeat (2) step();
        irq_raw = 4'h1;
        expect_at(L-1, "ovr_before", 4'h1, 4'hF, 4'h0);
        expect_at(L,   "ovr_set",    4'h1, 4'hF, 4'h1);
        repeat (L+1) step();
        cfg_we   = 1'b1;
        cfg_mode = 4'hF;
        expect_at(1, "ovr_clr", 4'h1, 4'hF, 4'h0);
        step();
        cfg_we    = 1'b0;
        ack_valid = 1'b1;
        ack_id    = 2'd0;
        expect_at(1, "ack0", 4'h0, 4'hF, 4'h0);
        step();
        ack_valid = 1'b0;
        irq_raw   = 4'h0;
        repeat (L+1) step();

        // Ack on line 3 coinciding with a new edge: set wins
        irq_raw = 4'h8;
        repeat (L+1) step();
        irq_raw = 4'h0;
        repeat (2) step();
        irq_raw = 4'h8;
        expect_at(L,   "setwins",   4'h8, 4'hF, 4'h0);
        expect_at(L+1, "setwins_b", 4'h8, 4'hF, 4'h0);
        repeat (L-1) step();
        ack_valid = 1'b1;
        ack_id    = 2'd3;
        step();
        ack_valid = 1'b0;
        step();
        ack_valid = 1'b1;
        ack_id    = 2'd3;
        expect_at(1, "ack3", 4'h0, 4'hF, 4'h0);
        step();
        ack_valid = 1'b0;
        irq_raw   = 4'h0;
        repeat (L+1) step();

        // Line 0 held high in level mode, then switched to edge: no spurious edge
        cfg_we   = 1'b1;
        cfg_mode = 4'hE;
        expect_at(1, "cfg_lvl0", 4'h0, 4'hE, 4'h0);
        step();
        cfg_we  = 1'b0;
        irq_raw = 4'h1;
        expect_at(L, "lvl0_hi", 4'h1, 4'hE, 4'h0);
        repeat (L+2) step();
        cfg_we   = 1'b1;
        cfg_mode = 4'hF;
        expect_at(1, "sw_clear",   4'h0, 4'hF, 4'h0);
        expect_at(4, "sw_nospur",  4'h0, 4'hF, 4'h0);
        step();
        cfg_we = 1'b0;
        repeat (4) step();

        // Reset overrides a simultaneous cfg write
        reset    = 1'b1;
        cfg_we   = 1'b1;
        cfg_mode = 4'h5;
        expect_at(1, "rst_over_cfg", 4'h0, 4'h0, 4'h0);
        step();
        reset  = 1'b0;
        cfg_we = 1'b0;
        irq_raw = 4'h0;
        step();
        n_cmp++;
        if (mode !== 4'h0 || overrun !== 4'h0) begin
            n_err++;
            $display("FAIL rst_over_cfg_direct: got mode=%h overrun=%h, want 0 0", mode, overrun);
        end

        // Drain the scoreboard with a bounded wait
        for (int t = 0; t < 20 && sb_q.size() > 0; t++) step();
        while (sb_q.size() > 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s: expectation for cyc=%0d never checked, want ext_int=%h",
                     sb_q[0].name, sb_q[0].cyc, sb_q[0].ext);
            void'(sb_q.pop_front());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
